// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline front end and the PC sequencer.
// The master drives redirect/handshake requests, the slave returns fetch state.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             input_flag;
  logic             output_flag;
  logic             insert;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             exc;
  logic             halt;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc;
  logic             io_wait;
  logic             io_timeout;
  logic             halted;

  modport master (
    output stall, input_flag, output_flag, insert,
    output branch_taken, branch_target, jump, jump_target,
    output exc, halt,
    input  pc_out, pc_next_seq, epc, io_wait, io_timeout, halted
  );

  modport slave (
    input  stall, input_flag, output_flag, insert,
    input  branch_taken, branch_target, jump, jump_target,
    input  exc, halt,
    output pc_out, pc_next_seq, epc, io_wait, io_timeout, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential step, redirects,
// exceptions, bounded I/O acknowledge wait with timeout trap, and halt.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      IO_TIMEOUT   = 5
) (
  input logic          CLK,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned    CW       = $clog2(IO_TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] epc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             io_timeout_reg;

  logic [WIDTH-1:0] pc_seq_next;
  logic [WIDTH-1:0] jump_aligned;
  logic [WIDTH-1:0] branch_aligned;
  logic             io_req;
  logic             unused_bits;

  assign pc_seq_next    = pc_reg + WIDTH'(STEP);
  assign jump_aligned   = {bus.jump_target[WIDTH-1:2], 2'b00};
  assign branch_aligned = {bus.branch_target[WIDTH-1:2], 2'b00};
  assign io_req         = bus.input_flag | bus.output_flag;
  assign unused_bits    = ^{bus.jump_target[1:0], bus.branch_target[1:0]};

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      pc_reg         <= RESET_VECTOR;
      epc_reg        <= '0;
      cnt_reg        <= '0;
      io_timeout_reg <= 1'b0;
    end else begin
      io_timeout_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          // Exception outranks halt so a faulting instruction is never lost.
          if (bus.exc) begin
            epc_reg <= pc_reg;
            pc_reg  <= EXC_VECTOR;
          end else if (bus.halt) begin
            state_reg <= ST_HALTED;
          end else if (bus.jump) begin
            pc_reg <= jump_aligned;
          end else if (bus.branch_taken) begin
            pc_reg <= branch_aligned;
          end else if (bus.stall) begin
            pc_reg <= pc_reg;
          end else if (io_req && !bus.insert) begin
            state_reg <= ST_IO_WAIT;
            cnt_reg   <= '0;
          end else begin
            pc_reg <= pc_seq_next;
          end
        end

        ST_IO_WAIT: begin
          // An acknowledge arriving on the expiry cycle still completes the transfer.
          if (bus.exc) begin
            epc_reg   <= pc_reg;
            pc_reg    <= EXC_VECTOR;
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else if (bus.insert) begin
            pc_reg    <= pc_seq_next;
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            io_timeout_reg <= 1'b1;
            epc_reg        <= pc_reg;
            pc_reg         <= EXC_VECTOR;
            state_reg      <= ST_RUN;
            cnt_reg        <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_HALTED: begin
          state_reg <= ST_HALTED;
        end

        default: begin
          state_reg <= ST_RUN;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.pc_out      = pc_reg;
  assign bus.pc_next_seq = pc_seq_next;
  assign bus.epc         = epc_reg;
  assign bus.io_wait     = (state_reg == ST_IO_WAIT);
  assign bus.halted      = (state_reg == ST_HALTED);
  assign bus.io_timeout  = io_timeout_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations for stepping,
// redirects, I/O wait and timeout, wraparound, exception and halt.
module tb_pc_sequencer;

  logic CLK = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h0000_0080), .IO_TIMEOUT(5)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.input_flag = 0; bus.output_flag = 0; bus.insert = 0;
    bus.branch_taken = 0; bus.branch_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.exc = 0; bus.halt = 0;
  endtask

  task automatic jump_to(input logic [31:0] target);
    bus.jump = 1; bus.jump_target = target;
    step();
    bus.jump = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step(); step();
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_io_wait", {31'b0, bus.io_wait}, 32'h0);
    check("rst_io_timeout", {31'b0, bus.io_timeout}, 32'h0);
    check("rst_halted", {31'b0, bus.halted}, 32'h0);
    reset = 0;

    check("free_pc0", bus.pc_out, 32'h0);
    step(); check("free_pc4", bus.pc_out, 32'h4);
    step(); check("free_pc8", bus.pc_out, 32'h8);
    step(); check("free_pc12", bus.pc_out, 32'hC);
    reset = 1;
    step();
    check("midrst_pc", bus.pc_out, 32'h0);
    check("midrst_io_wait", {31'b0, bus.io_wait}, 32'h0);
    reset = 0;

    jump_to(32'h10);
    check("jmp_setup", bus.pc_out, 32'h10);
    bus.jump = 1; bus.jump_target = 32'h203;
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    step();
    check("jump_over_branch", bus.pc_out, 32'h200);
    clear_inputs();
    bus.stall = 1;
    step();
    check("stall_hold", bus.pc_out, 32'h200);
    bus.stall = 0;

    jump_to(32'h20);
    bus.input_flag = 1;
    step();
    check("iw_enter", {31'b0, bus.io_wait}, 32'h1);
    check("iw_pc_hold", bus.pc_out, 32'h20);
    bus.input_flag = 0;
    step(); step();
    check("iw_still_wait", {31'b0, bus.io_wait}, 32'h1);
    bus.insert = 1;
    step();
    bus.insert = 0;
    check("iw_ack_pc", bus.pc_out, 32'h24);
    check("iw_ack_exit", {31'b0, bus.io_wait}, 32'h0);

    jump_to(32'h30);
    bus.output_flag = 1;
    step();
    bus.output_flag = 0;
    check("to_enter", {31'b0, bus.io_wait}, 32'h1);
    for (int i = 0; i < 4; i++) step();
    check("to_pre_wait", {31'b0, bus.io_wait}, 32'h1);
    check("to_pre_pulse", {31'b0, bus.io_timeout}, 32'h0);
    check("to_pre_pc", bus.pc_out, 32'h30);
    step();
    check("to_pc", bus.pc_out, 32'h80);
    check("to_epc", bus.epc, 32'h30);
    check("to_pulse", {31'b0, bus.io_timeout}, 32'h1);
    check("to_exit", {31'b0, bus.io_wait}, 32'h0);
    step();
    check("to_pulse_drop", {31'b0, bus.io_timeout}, 32'h0);
    check("to_resume", bus.pc_out, 32'h84);

    jump_to(32'hFFFF_FFFC);
    check("wrap_setup", bus.pc_out, 32'hFFFF_FFFC);
    check("wrap_next_seq", bus.pc_next_seq, 32'h0);
    step(); check("wrap_pc", bus.pc_out, 32'h0);
    step(); step();
    check("exc_setup", bus.pc_out, 32'h8);
    bus.exc = 1; bus.halt = 1;
    step();
    clear_inputs();
    check("exc_halt_pc", bus.pc_out, 32'h80);
    check("exc_halt_epc", bus.epc, 32'h8);
    check("exc_halt_halted", {31'b0, bus.halted}, 32'h0);

    jump_to(32'h44);
    bus.halt = 1;
    step();
    bus.halt = 0;
    check("halt_enter", {31'b0, bus.halted}, 32'h1);
    check("halt_pc", bus.pc_out, 32'h44);
    bus.jump = 1; bus.jump_target = 32'h100; bus.exc = 1; bus.input_flag = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("halt_hold_pc%0d", i), bus.pc_out, 32'h44);
    end
    check("halt_hold_epc", bus.epc, 32'h8);
    check("halt_still", {31'b0, bus.halted}, 32'h1);
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    check("halt_rst_pc", bus.pc_out, 32'h0);
    check("halt_rst_halted", {31'b0, bus.halted}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
